sb_rx_pkt_decoder: RTL and testbench
====================================

Name: sb_rx_pkt_decoder

Overview:
- Parametrised next-generation sideband RX packet decoder.
- Sits between the sideband deserializer and the header/data decoders and the LTSM.
- Hunts for the alternating sideband training pattern and declares lock after a programmable number of consecutive pattern words.
- After lock, splits the word stream into headers and 1..MAX_DATA_BEATS data beats, checks header and data parity, and enforces an inter-beat timeout.
- Reports error events and keeps a saturating error count.

Parameters:
- PKT_W, 64: sideband word width. Even, >= 32.
- PATTERN_REQ, 2: consecutive pattern words needed for lock. Range 1..15.
- MAX_DATA_BEATS, 2: maximum data beats per message. Range 1..4.
- TIMEOUT_CYC, 255: maximum idle cycles allowed between data beats. Must be > 0.
- ERR_CNT_W, 8: error counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_word_valid  in  1  deserializer word strobe. 1-cycle pulse.
- i_word  in  PKT_W  deserialized word.
- i_ltsm_in_reset  in  1  LTSM reset state: forces re-hunt.
- o_pattern_lock  out  1  pattern lock achieved.
- o_hdr_valid  out  1  pulse: good header on o_hdr.
- o_hdr  out  PKT_W  captured header.
- o_data_valid  out  1  pulse: good data beat on o_data.
- o_data  out  PKT_W  data beat.
- o_data_last  out  1  qualifies o_data_valid: final beat.
- o_msg_valid  out  1  pulse: complete message delivered.
- o_rsp_delivered  out  1  pulse with o_hdr_valid when the header is a response.
- o_parity_error  out  1  pulse: header or data parity fail.
- o_timeout_error  out  1  pulse: data beat timeout.
- o_err_cnt  out  ERR_CNT_W  saturating error count.

Behaviour:
- Reset: i_rst is synchronous and active-high, on the single clock i_clk. All outputs go to 0 and the FSM goes to HUNT.
- Latency: every output is registered. Each output appears exactly 1 cycle after the i_word_valid cycle that caused it.
- Pattern word: i_word == {PKT_W/2{2'b10}}, so the MSB is 1.
- Header parity: good when ^i_word[PKT_W-2:0] == 0. Bit PKT_W-1 is dp, the data parity bit, and is latched with the header.
- Opcode is i_word[4:0]. Beat count comes from the package table:
  - OPC_NODATA (5'b10010): 0 beats.
  - OPC_D64 (5'b11011): 1 beat.
  - OPC_D128 (5'b11100): 2 beats.
  - Any other opcode: 0 beats.
  - If the beat count exceeds MAX_DATA_BEATS, the message is treated as a bad packet.
- Response header: i_word[17:14] == 4'hA.

FSM states:
- HUNT:
  - A pattern word increments pat_cnt. Any other word clears it.
  - When pat_cnt reaches PATTERN_REQ, set o_pattern_lock = 1 and go to WAIT_HDR.
  - PATTERN_REQ = 1 locks on the first pattern word.
- WAIT_HDR:
  - Pattern words are ignored.
  - Bad header parity: pulse o_parity_error. Go to DROP if the opcode carries data, otherwise stay in WAIT_HDR.
  - Good header, 0 beats: pulse o_hdr_valid and o_msg_valid.
  - Good header, N beats: pulse o_hdr_valid, load beats_left = N, load the timer, go to DATA.
  - Beat count > MAX_DATA_BEATS: pulse o_parity_error (the bad-packet error pulse) and go to DROP with beats_left = N.
- DATA:
  - Each word must satisfy ^{i_word, dp} == 0.
  - Good beat: pulse o_data_valid and decrement beats_left.
  - Good final beat: also pulse o_data_last and o_msg_valid, then return to WAIT_HDR.
  - Bad parity: pulse o_parity_error, drop the remaining beats (DROP), and do not pulse o_msg_valid.
  - The timer reloads to TIMEOUT_CYC on every word and decrements otherwise. At 0: pulse o_timeout_error and go to WAIT_HDR.
- DROP: consume beats_left words with no output, then go to WAIT_HDR. The timer also applies here.
- i_ltsm_in_reset, from any state: next state HUNT; clear o_pattern_lock, pat_cnt and beats_left; no output pulses. It has priority over a simultaneous word.
- o_err_cnt: increments on each o_parity_error or o_timeout_error pulse and saturates at all-ones. It is cleared only by i_rst.
- Simultaneous word and timer expiry: the word wins and the timer reloads.

Decomposition:
- Package sb_rx_pkg holds:
  - the state enum;
  - the opcode constants;
  - a beats_for_opcode function;
  - a pattern function parametrised by width;
  - the MsgCode field bit positions.
- One sub-module: sb_rx_beat_timer (loadable down-counter with expiry pulse).

Test Plan:
- Lock: PATTERN_REQ=2; send 0xAAAA_AAAA_AAAA_AAAA, a non-pattern word, then two pattern words. Expected: o_pattern_lock rises 1 cycle after the 4th word, not after the 1st.
- Header-only: after lock, send an even-parity header with opcode 5'b10010 and [17:14]=4'hA. Expected: o_hdr_valid, o_msg_valid and o_rsp_delivered pulse together; o_hdr equals the word.
- Two-beat message: send an OPC_D128 header with dp=0, then two even-parity beats. Expected: two o_data_valid pulses; o_data_last and o_msg_valid on the 2nd pulse.
- Data parity error: send an OPC_D64 header, then a beat with odd parity. Expected: o_parity_error pulse, no o_msg_valid, o_err_cnt=1; the next header decodes normally.
- Timeout: TIMEOUT_CYC=4; send an OPC_D64 header and no beat. Expected: o_timeout_error pulses 5 cycles after the header, FSM returns to WAIT_HDR, o_err_cnt increments.
- LTSM reset and saturation:
  - Assert i_ltsm_in_reset mid-DATA. Expected: o_pattern_lock drops next cycle and the FSM re-hunts.
  - Force 300 errors with ERR_CNT_W=8. Expected: o_err_cnt holds at 255.

Source files
------------

// File: rtl/sb_rx_pkg.sv
// Shared types, opcode table and field positions for the sideband RX decoder.
package sb_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_WAIT_HDR,
        ST_DATA,
        ST_DROP
    } sb_rx_state_e;

    localparam logic [4:0] OPC_NODATA = 5'b10010;
    localparam logic [4:0] OPC_D64    = 5'b11011;
    localparam logic [4:0] OPC_D128   = 5'b11100;

    localparam int OPC_LSB     = 0;
    localparam int OPC_MSB     = 4;
    localparam int MSGCODE_LSB = 14;
    localparam int MSGCODE_MSB = 17;
    localparam logic [3:0] MSGCODE_RSP = 4'hA;

    localparam int MAX_PKT_W = 128;

    function automatic logic [2:0] beats_for_opcode(input logic [4:0] opc);
        logic [2:0] n;
        case (opc)
            OPC_D64:  n = 3'd1;
            OPC_D128: n = 3'd2;
            default:  n = 3'd0;
        endcase
        return n;
    endfunction

    // Alternating 1010... pattern, MSB first, for any width up to MAX_PKT_W.
    function automatic logic [MAX_PKT_W-1:0] sb_pattern(input int w);
        logic [MAX_PKT_W-1:0] p;
        for (int i = 0; i < MAX_PKT_W; i++) begin
            p[i] = (i % 2 == 1) && (i < w);
        end
        return p;
    endfunction

endpackage

// File: rtl/sb_rx_beat_timer.sv
// Loadable down-counter; flags expiry while running at zero without a reload.
module sb_rx_beat_timer
#(
    parameter int unsigned LOAD_VAL = 255
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(LOAD_VAL + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = CNT_W'(LOAD_VAL);
        end else if (i_run && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = i_run && !i_load && (count_q == '0);

endmodule

// File: rtl/sb_rx_pkt_decoder.sv
// Sideband RX decoder: pattern lock, header/data split, parity and timeout checks.
//   state       | meaning
//   ST_HUNT     | counting consecutive training-pattern words
//   ST_WAIT_HDR | locked, next non-pattern word is a header
//   ST_DATA     | delivering data beats of the current message
//   ST_DROP     | consuming remaining beats of a rejected message
module sb_rx_pkt_decoder
    import sb_rx_pkg::*;
#(
    parameter int unsigned PKT_W          = 64,
    parameter int unsigned PATTERN_REQ    = 2,
    parameter int unsigned MAX_DATA_BEATS = 2,
    parameter int unsigned TIMEOUT_CYC    = 255,
    parameter int unsigned ERR_CNT_W      = 8
)
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_word_valid,
    input  logic [PKT_W-1:0]     i_word,
    input  logic                 i_ltsm_in_reset,
    output logic                 o_pattern_lock,
    output logic                 o_hdr_valid,
    output logic [PKT_W-1:0]     o_hdr,
    output logic                 o_data_valid,
    output logic [PKT_W-1:0]     o_data,
    output logic                 o_data_last,
    output logic                 o_msg_valid,
    output logic                 o_rsp_delivered,
    output logic                 o_parity_error,
    output logic                 o_timeout_error,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam logic [MAX_PKT_W-1:0] PAT_FULL = sb_pattern(int'(PKT_W));
    localparam logic [PKT_W-1:0]     PATTERN  = PAT_FULL[PKT_W-1:0];

    sb_rx_state_e         state_q, state_d;
    logic [3:0]           pat_cnt_q, pat_cnt_d;
    logic [2:0]           beats_q, beats_d;
    logic                 dp_q, dp_d;
    logic                 lock_q, lock_d;
    logic [PKT_W-1:0]     hdr_q, hdr_d, data_q, data_d;
    logic                 hdr_v_q, hdr_v_d, data_v_q, data_v_d, last_q, last_d;
    logic                 msg_q, msg_d, rsp_q, rsp_d, perr_q, perr_d, tout_q, tout_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic       is_pat, hdr_par_ok, data_par_ok, is_rsp, expired;
    logic [2:0] opc_beats;

    assign is_pat      = (i_word == PATTERN);
    assign hdr_par_ok  = ~^i_word[PKT_W-2:0];
    assign data_par_ok = ~^{i_word, dp_q};
    assign is_rsp      = (i_word[MSGCODE_MSB:MSGCODE_LSB] == MSGCODE_RSP);
    assign opc_beats   = beats_for_opcode(i_word[OPC_MSB:OPC_LSB]);

    sb_rx_beat_timer #(.LOAD_VAL(TIMEOUT_CYC)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (i_word_valid),
        .i_run     (state_q inside {ST_DATA, ST_DROP}),
        .o_expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        pat_cnt_d = pat_cnt_q;
        beats_d   = beats_q;
        dp_d      = dp_q;
        lock_d    = lock_q;
        hdr_d     = hdr_q;
        data_d    = data_q;
        hdr_v_d   = 1'b0;
        data_v_d  = 1'b0;
        last_d    = 1'b0;
        msg_d     = 1'b0;
        rsp_d     = 1'b0;
        perr_d    = 1'b0;
        tout_d    = 1'b0;
        unique case (state_q)
            ST_HUNT: begin
                if (i_word_valid) begin
                    if (!is_pat) begin
                        pat_cnt_d = '0;
                    end else if (pat_cnt_q == 4'(PATTERN_REQ - 1)) begin
                        pat_cnt_d = '0;
                        lock_d    = 1'b1;
                        state_d   = ST_WAIT_HDR;
                    end else begin
                        pat_cnt_d = pat_cnt_q + 4'd1;
                    end
                end
            end
            ST_WAIT_HDR: begin
                if (i_word_valid && !is_pat) begin
                    dp_d = i_word[PKT_W-1];
                    if (!hdr_par_ok || opc_beats > 3'(MAX_DATA_BEATS)) begin
                        perr_d = 1'b1;
                        if (opc_beats != '0) begin
                            beats_d = opc_beats;
                            state_d = ST_DROP;
                        end
                    end else begin
                        hdr_v_d = 1'b1;
                        hdr_d   = i_word;
                        rsp_d   = is_rsp;
                        if (opc_beats == '0) begin
                            msg_d = 1'b1;
                        end else begin
                            beats_d = opc_beats;
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA, ST_DROP: begin
                if (i_word_valid) begin
                    beats_d = beats_q - 3'd1;
                    if (state_q == ST_DATA && data_par_ok) begin
                        data_v_d = 1'b1;
                        data_d   = i_word;
                        last_d   = (beats_q == 3'd1);
                        msg_d    = (beats_q == 3'd1);
                    end else if (state_q == ST_DATA) begin
                        perr_d = 1'b1;
                    end
                    state_d = (beats_q == 3'd1) ? ST_WAIT_HDR : state_d;
                    if (state_q == ST_DATA && !data_par_ok && beats_q != 3'd1) begin
                        state_d = ST_DROP;
                    end
                end else if (expired) begin
                    tout_d  = 1'b1;
                    beats_d = '0;
                    state_d = ST_WAIT_HDR;
                end
            end
            default: state_d = ST_HUNT;
        endcase
        // LTSM reset overrides whatever the word would have done.
        if (i_ltsm_in_reset) begin
            state_d   = ST_HUNT;
            pat_cnt_d = '0;
            beats_d   = '0;
            lock_d    = 1'b0;
            dp_d      = dp_q;
            hdr_d     = hdr_q;
            data_d    = data_q;
            hdr_v_d   = 1'b0;
            data_v_d  = 1'b0;
            last_d    = 1'b0;
            msg_d     = 1'b0;
            rsp_d     = 1'b0;
            perr_d    = 1'b0;
            tout_d    = 1'b0;
        end
        err_d = err_q;
        if ((perr_d || tout_d) && err_q != '1) begin
            err_d = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_HUNT;
            pat_cnt_q <= '0;
            beats_q   <= '0;
            dp_q      <= 1'b0;
            lock_q    <= 1'b0;
            hdr_q     <= '0;
            data_q    <= '0;
            hdr_v_q   <= 1'b0;
            data_v_q  <= 1'b0;
            last_q    <= 1'b0;
            msg_q     <= 1'b0;
            rsp_q     <= 1'b0;
            perr_q    <= 1'b0;
            tout_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            pat_cnt_q <= pat_cnt_d;
            beats_q   <= beats_d;
            dp_q      <= dp_d;
            lock_q    <= lock_d;
            hdr_q     <= hdr_d;
            data_q    <= data_d;
            hdr_v_q   <= hdr_v_d;
            data_v_q  <= data_v_d;
            last_q    <= last_d;
            msg_q     <= msg_d;
            rsp_q     <= rsp_d;
            perr_q    <= perr_d;
            tout_q    <= tout_d;
            err_q     <= err_d;
        end
    end

    assign o_pattern_lock  = lock_q;
    assign o_hdr_valid     = hdr_v_q;
    assign o_hdr           = hdr_q;
    assign o_data_valid    = data_v_q;
    assign o_data          = data_q;
    assign o_data_last     = last_q;
    assign o_msg_valid     = msg_q;
    assign o_rsp_delivered = rsp_q;
    assign o_parity_error  = perr_q;
    assign o_timeout_error = tout_q;
    assign o_err_cnt       = err_q;

endmodule

// File: tb/tb_sb_rx_pkt_decoder.sv
// Randomized bench for sb_rx_pkt_decoder against a message-level reference model.
module tb_sb_rx_pkt_decoder;

    localparam int PKT_W   = 64;
    localparam int PAT_REQ = 2;
    localparam int MAX_DB  = 2;
    localparam int TMO     = 4;
    localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_word_valid = 1'b0;
    logic [63:0] i_word = '0;
    logic        i_ltsm_in_reset = 1'b0;
    logic        o_pattern_lock, o_hdr_valid, o_data_valid, o_data_last;
    logic        o_msg_valid, o_rsp_delivered, o_parity_error, o_timeout_error;
    logic [63:0] o_hdr, o_data;
    logic [7:0]  o_err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state: expected outputs plus message bookkeeping
    logic        e_lock, e_hdr_v, e_data_v, e_last, e_msg, e_rsp, e_perr, e_tout;
    logic [63:0] e_hdr, e_data;
    logic [7:0]  e_err;
    int          m_pat, m_pend, m_idle;
    logic        m_deliver, m_dp;

    always #5 clk = ~clk;

    sb_rx_pkt_decoder #(
        .PKT_W(PKT_W), .PATTERN_REQ(PAT_REQ), .MAX_DATA_BEATS(MAX_DB),
        .TIMEOUT_CYC(TMO), .ERR_CNT_W(8)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_word_valid(i_word_valid), .i_word(i_word),
        .i_ltsm_in_reset(i_ltsm_in_reset), .o_pattern_lock(o_pattern_lock),
        .o_hdr_valid(o_hdr_valid), .o_hdr(o_hdr), .o_data_valid(o_data_valid),
        .o_data(o_data), .o_data_last(o_data_last), .o_msg_valid(o_msg_valid),
        .o_rsp_delivered(o_rsp_delivered), .o_parity_error(o_parity_error),
        .o_timeout_error(o_timeout_error), .o_err_cnt(o_err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int tb_beats(input logic [4:0] opc);
        if (opc == 5'b11011) return 1;
        if (opc == 5'b11100) return 2;
        return 0;
    endfunction

    task automatic model(input logic v, input logic [63:0] w, input logic lr, input logic rst);
        int n;
        {e_hdr_v, e_data_v, e_last, e_msg, e_rsp, e_perr, e_tout} = '0;
        if (rst) begin
            e_lock = 0; e_hdr = '0; e_data = '0; e_err = '0;
            m_pat = 0; m_pend = 0; m_idle = 0; m_deliver = 0; m_dp = 0;
        end else if (lr) begin
            e_lock = 0; m_pat = 0; m_pend = 0;
        end else if (!e_lock) begin
            if (v) begin
                m_pat = (w == PAT) ? m_pat + 1 : 0;
                if (m_pat == PAT_REQ) begin
                    e_lock = 1; m_pat = 0;
                end
            end
        end else if (m_pend == 0) begin
            if (v && w != PAT) begin
                n = tb_beats(w[4:0]);
                m_dp = w[63];
                m_idle = 0;
                if ((^w[62:0]) != 1'b0 || n > MAX_DB) begin
                    e_perr = 1; m_pend = n; m_deliver = 0;
                end else begin
                    e_hdr_v = 1; e_hdr = w; e_rsp = (w[17:14] == 4'hA);
                    if (n == 0) e_msg = 1;
                    else begin m_pend = n; m_deliver = 1; end
                end
            end
        end else begin
            if (v) begin
                m_idle = 0;
                m_pend--;
                if (m_deliver) begin
                    if ((^{w, m_dp}) == 1'b0) begin
                        e_data_v = 1; e_data = w;
                        if (m_pend == 0) begin e_last = 1; e_msg = 1; end
                    end else begin
                        e_perr = 1; m_deliver = 0;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle > TMO) begin e_tout = 1; m_pend = 0; end
            end
        end
        if ((e_perr || e_tout) && e_err != 8'hFF) e_err = e_err + 8'd1;
    endtask

    task automatic compare_all();
        chk("lock", 64'(o_pattern_lock), 64'(e_lock));
        chk("hdr_valid", 64'(o_hdr_valid), 64'(e_hdr_v));
        chk("hdr", o_hdr, e_hdr);
        chk("data_valid", 64'(o_data_valid), 64'(e_data_v));
        chk("data", o_data, e_data);
        chk("data_last", 64'(o_data_last), 64'(e_last));
        chk("msg_valid", 64'(o_msg_valid), 64'(e_msg));
        chk("rsp", 64'(o_rsp_delivered), 64'(e_rsp));
        chk("parity_err", 64'(o_parity_error), 64'(e_perr));
        chk("timeout_err", 64'(o_timeout_error), 64'(e_tout));
        chk("err_cnt", 64'(o_err_cnt), 64'(e_err));
    endtask

    task automatic step(input logic v, input logic [63:0] w, input logic lr, input logic rst);
        @(negedge clk);
        i_word_valid = v; i_word = w; i_ltsm_in_reset = lr; i_rst = rst;
        @(posedge clk);
        model(v, w, lr, rst);
        #1 compare_all();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [4:0] opc, input logic good,
                                           input logic dp, input logic rsp);
        logic [63:0] w;
        w = rnd64();
        w[4:0] = opc;
        if (rsp) w[17:14] = 4'hA;
        else if (w[17:14] == 4'hA) w[14] = ~w[14];
        w[63] = dp;
        if ((^w[62:0]) != !good) w[10] = ~w[10];
        if (w == PAT) begin w[20] = ~w[20]; w[21] = ~w[21]; end
        return w;
    endfunction

    function automatic logic [63:0] mk_beat(input logic good, input logic dp);
        logic [63:0] w;
        w = rnd64();
        if ((^{w, dp}) != !good) w[0] = ~w[0];
        return w;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rnd64(), 1'b0, 1'b0);
    endtask

    task automatic send(input logic [63:0] w);
        step(1'b1, w, 1'b0, 1'b0);
    endtask

    logic [63:0] w0;
    logic [4:0]  opc;
    logic        dp;

    initial begin
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, PAT, 1'b0, 1'b1);
        idle(1);

        // lock: pattern, junk, pattern, pattern
        send(PAT);
        chk("no_lock_after_1st", 64'(o_pattern_lock), 64'd0);
        send(64'h1234_5678_9ABC_DEF0);
        send(PAT);
        send(PAT);
        chk("lock_after_4th", 64'(o_pattern_lock), 64'd1);

        // header-only response
        w0 = mk_hdr(5'b10010, 1'b1, 1'b0, 1'b1);
        send(w0);
        chk("hdr_only_valid", 64'({o_hdr_valid, o_msg_valid, o_rsp_delivered}), 64'd7);
        chk("hdr_only_word", o_hdr, w0);

        // two-beat message
        send(mk_hdr(5'b11100, 1'b1, 1'b0, 1'b0));
        send(mk_beat(1'b1, 1'b0));
        chk("d128_beat1_last", 64'({o_data_valid, o_data_last}), 64'd2);
        idle(1);
        send(mk_beat(1'b1, 1'b0));
        chk("d128_beat2_last", 64'({o_data_valid, o_data_last, o_msg_valid}), 64'd7);

        // data parity error, then a normal header
        dp = 1'b1;
        send(mk_hdr(5'b11011, 1'b1, dp, 1'b0));
        send(mk_beat(1'b0, dp));
        chk("dperr_pulse", 64'({o_parity_error, o_msg_valid}), 64'd2);
        chk("dperr_cnt", 64'(o_err_cnt), 64'd1);
        send(mk_hdr(5'b10010, 1'b1, 1'b0, 1'b0));
        chk("after_dperr_hdr", 64'(o_hdr_valid), 64'd1);

        // timeout: header with no beat
        send(mk_hdr(5'b11011, 1'b1, 1'b0, 1'b0));
        idle(4);
        chk("no_tout_early", 64'(o_timeout_error), 64'd0);
        idle(1);
        chk("tout_pulse", 64'(o_timeout_error), 64'd1);
        chk("tout_cnt", 64'(o_err_cnt), 64'd2);
        send(mk_hdr(5'b10010, 1'b1, 1'b0, 1'b0));
        chk("after_tout_hdr", 64'(o_hdr_valid), 64'd1);

        // LTSM reset mid-DATA, with a simultaneous word
        send(mk_hdr(5'b11100, 1'b1, 1'b0, 1'b0));
        step(1'b1, mk_beat(1'b1, 1'b0), 1'b1, 1'b0);
        chk("ltsm_lock_drop", 64'({o_pattern_lock, o_data_valid}), 64'd0);
        send(mk_beat(1'b1, 1'b0));
        send(PAT);
        send(PAT);
        chk("relock", 64'(o_pattern_lock), 64'd1);

        // randomized traffic
        for (int ep = 0; ep < 250; ep++) begin
            int r, n;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                step(1'($urandom), rnd64(), 1'b1, 1'b0);
            end else if (r < 4) begin
                for (int k = 0; k < $urandom_range(1, 3); k++) send(PAT);
            end else if (r < 6) begin
                send(rnd64());
                idle($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 3))
                    0: opc = 5'b10010;
                    1: opc = 5'b11011;
                    2: opc = 5'b11100;
                    default: opc = 5'($urandom);
                endcase
                dp = 1'($urandom);
                send(mk_hdr(opc, ($urandom_range(0, 7) != 0), dp, 1'($urandom)));
                n = tb_beats(opc);
                for (int b = 0; b < n; b++) begin
                    idle(($urandom_range(0, 11) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 2));
                    send(mk_beat(($urandom_range(0, 7) != 0), dp));
                end
                idle($urandom_range(0, 1));
            end
        end

        // error counter saturation
        step(1'b0, '0, 1'b1, 1'b0);
        send(PAT);
        send(PAT);
        for (int k = 0; k < 300; k++) send(mk_hdr(5'b10010, 1'b0, 1'b0, 1'b0));
        idle(2);
        chk("err_sat", 64'(o_err_cnt), 64'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
